// File: rtl/aes_pkg.sv
// Shared types and constants for the streaming AES controller.
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    typedef enum logic {
        ECB = 1'b0,
        CBC = 1'b1
    } mode_t;

endpackage

// File: rtl/aes_blk_fifo.sv
// Block-wide input FIFO; extra pointer MSB distinguishes full from empty.
module aes_blk_fifo #(
    parameter int unsigned BLK_W      = 128,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [BLK_W-1:0] wr_data,
    output logic [BLK_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [BLK_W-1:0] mem [FIFO_DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign head  = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Buffers plaintext blocks and sequences an external iterative AES core (ECB/CBC).
module aes_stream_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned BLK_W      = AES_BLK_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             mode,
    input  logic             iv_load,
    input  logic [BLK_W-1:0] iv,
    output logic             core_start,
    output logic [BLK_W-1:0] core_data,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic [CNT_W-1:0] blk_count,
    output logic             busy,
    output logic             err
);

    state_t           state;
    state_t           state_d;
    mode_t            mode_q;
    logic [BLK_W-1:0] chain;
    logic [BLK_W-1:0] fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    aes_blk_fifo #(
        .BLK_W      (BLK_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_data),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        fifo_pop = 1'b0;
        case (state)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE: begin
                fifo_pop = 1'b1;
                state_d  = WAIT;
            end
            WAIT:    if (core_done) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // core_start and core_data launch together at the end of ISSUE so the core sees both at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= ECB;
            chain      <= '0;
            core_start <= 1'b0;
            core_data  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            blk_count  <= '0;
            err        <= 1'b0;
        end else begin
            core_start <= (state == ISSUE);
            out_valid  <= (state_d == OUT);
            if (core_done && (state != WAIT)) err <= 1'b1;
            case (state)
                IDLE:  if (iv_load) chain <= iv;
                ISSUE: begin
                    mode_q    <= mode_t'(mode);
                    core_data <= mode ? (fifo_head ^ chain) : fifo_head;
                end
                WAIT: begin
                    if (core_done) begin
                        out_data <= core_result;
                        if (mode_q == CBC) chain <= core_result;
                    end
                end
                OUT:   if (out_ready) blk_count <= blk_count + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with a behavioural AES-128 core and an expected-output queue.
module tb_aes_stream_ctrl;

    localparam int unsigned BLK_W    = 128;
    localparam int unsigned CNT_W    = 16;
    localparam int          CORE_LAT = 11;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             tb_clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic             mode;
    logic             iv_load;
    logic [BLK_W-1:0] iv;
    logic             core_start;
    logic [BLK_W-1:0] core_data;
    logic             core_done;
    logic [BLK_W-1:0] core_result;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_data;
    logic [CNT_W-1:0] blk_count;
    logic             busy;
    logic             err;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [127:0]     exp_q[$];
    logic [127:0]     tb_chain;
    logic [CNT_W-1:0] exp_count;
    logic             stray_req = 1'b0;

    logic [7:0]       sbox [256];
    logic [127:0]     rk   [11];
    int               core_cnt;
    logic [127:0]     core_pend;

    always #5 tb_clk = ~tb_clk;

    aes_stream_ctrl #(
        .BLK_W      (BLK_W),
        .FIFO_DEPTH (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mode        (mode),
        .iv_load     (iv_load),
        .iv          (iv),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .blk_count   (blk_count),
        .busy        (busy),
        .err         (err)
    );

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] b;
        b = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[b[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w+4*c] = s[w + 4*((c+w)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) b[127-8*i -: 8] = s[i];
            b = b ^ rk[r];
        end
        return b;
    endfunction

    task automatic aes_init();
        logic [127:0] row [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] key;
        row[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
        row[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
        row[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
        row[3]  = 128'h04c723c31896059a071280e2eb27b275;
        row[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
        row[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
        row[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
        row[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
        row[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
        row[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
        row[10] = 128'he0323a0a4906245cc2d3ac629195e479;
        row[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
        row[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
        row[13] = 128'h703eb5664803f60e613557b986c11d9e;
        row[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
        row[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) sbox[16*r+c] = row[r][127-8*c -: 8];
        key = 128'h000102030405060708090a0b0c0d0e0f;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Iterative core model: done pulses CORE_LAT cycles after the sampled start.
    always @(posedge tb_clk) begin
        if (rst) begin
            core_cnt  <= 0;
            core_done <= 1'b0;
        end else begin
            core_done <= (core_cnt == 1) || stray_req;
            if (core_cnt == 1) core_result <= core_pend;
            if (core_start) begin
                core_pend <= aes_enc(core_data);
                core_cnt  <= CORE_LAT;
            end else if (core_cnt > 0) begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
        exp_q.delete();
        tb_chain  = '0;
        exp_count = '0;
    endtask

    task automatic load_iv(input logic [127:0] v);
        iv      = v;
        iv_load = 1'b1;
        @(negedge tb_clk);
        iv_load  = 1'b0;
        tb_chain = v;
    endtask

    task automatic push_blk(input logic [127:0] pt);
        int           n;
        logic [127:0] e;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge tb_clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("push_ready_timeout", 128'(in_ready), 128'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = pt;
        if (mode) begin
            e        = aes_enc(pt ^ tb_chain);
            tb_chain = e;
        end else begin
            e = aes_enc(pt);
        end
        exp_q.push_back(e);
        @(negedge tb_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge tb_clk);
            n++;
        end
        if (out_valid !== 1'b1) check({tag, "_valid_timeout"}, 128'(out_valid), 128'd1);
    endtask

    task automatic get_out(input string tag);
        logic [127:0] e;
        wait_out(tag);
        if (out_valid !== 1'b1) return;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 128'(exp_q.size()), 128'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_data"}, out_data, e);
        out_ready = 1'b1;
        @(negedge tb_clk);
        out_ready = 1'b0;
        exp_count = exp_count + CNT_W'(1);
        check({tag, "_count"}, 128'(blk_count), 128'(exp_count));
        check({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk;
        aes_init();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        iv_load   = 1'b0;
        iv        = '0;
        out_ready = 1'b0;
        @(negedge tb_clk);
        do_reset();

        // Reset state
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_blk_count", 128'(blk_count), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_core_start", 128'(core_start), 128'd0);
        check("rst_out_data", out_data, 128'd0);

        // 1: ECB known answer, plus issue latency
        mode = 1'b0;
        push_blk(KAT_PT);
        check("t1_model_kat", exp_q[0], KAT_CT);
        check("t1_start_c1", 128'(core_start), 128'd0);
        check("t1_busy", 128'(busy), 128'd1);
        @(negedge tb_clk);
        check("t1_start_c2", 128'(core_start), 128'd0);
        @(negedge tb_clk);
        check("t1_start_c3", 128'(core_start), 128'd1);
        check("t1_core_data", core_data, KAT_PT);
        wait_out("t1");
        check("t1_kat", out_data, KAT_CT);
        get_out("t1");
        check("t1_idle_busy", 128'(busy), 128'd0);

        // 2: CBC with zero IV, same block twice
        mode = 1'b1;
        load_iv('0);
        push_blk(KAT_PT);
        push_blk(KAT_PT);
        wait_out("t2_b0");
        check("t2_b0_kat", out_data, KAT_CT);
        get_out("t2_b0");
        get_out("t2_b1");

        // 3: fill the FIFO behind one in-flight block; order preserved
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            blk = {$urandom(), $urandom(), $urandom(), $urandom()};
            push_blk(blk);
        end
        check("t3_full_in_ready", 128'(in_ready), 128'd0);
        check("t3_busy", 128'(busy), 128'd1);
        for (int i = 0; i < 5; i++) get_out($sformatf("t3_b%0d", i));
        check("t3_drained_in_ready", 128'(in_ready), 128'd1);

        // 4: backpressure holds OUT and blocks the next issue
        push_blk({$urandom(), $urandom(), $urandom(), $urandom()});
        push_blk({$urandom(), $urandom(), $urandom(), $urandom()});
        wait_out("t4_hold");
        for (int i = 0; i < 20; i++) begin
            check("t4_hold_data", out_data, exp_q[0]);
            check("t4_hold_start", 128'(core_start), 128'd0);
            check("t4_hold_valid", 128'(out_valid), 128'd1);
            @(negedge tb_clk);
        end
        get_out("t4_a");
        check("t4_restart_c1", 128'(core_start), 128'd0);
        @(negedge tb_clk);
        check("t4_restart_c2", 128'(core_start), 128'd0);
        @(negedge tb_clk);
        check("t4_restart_c3", 128'(core_start), 128'd1);
        get_out("t4_b");

        // 5: stray core_done while idle
        stray_req = 1'b1;
        @(negedge tb_clk);
        stray_req = 1'b0;
        @(negedge tb_clk);
        check("t5_err_set", 128'(err), 128'd1);
        check("t5_no_out", 128'(out_valid), 128'd0);
        push_blk(KAT_PT);
        get_out("t5_data");
        check("t5_err_sticky", 128'(err), 128'd1);
        do_reset();
        check("t5_err_clear", 128'(err), 128'd0);

        // 6: reset in WAIT with two blocks queued; chain returns to zero
        mode = 1'b1;
        load_iv({$urandom(), $urandom(), $urandom(), $urandom()});
        push_blk({$urandom(), $urandom(), $urandom(), $urandom()});
        get_out("t6_pre");
        push_blk({$urandom(), $urandom(), $urandom(), $urandom()});
        push_blk({$urandom(), $urandom(), $urandom(), $urandom()});
        push_blk({$urandom(), $urandom(), $urandom(), $urandom()});
        check("t6_in_wait_start", 128'(core_start), 128'd1);
        do_reset();
        check("t6_out_valid", 128'(out_valid), 128'd0);
        check("t6_in_ready", 128'(in_ready), 128'd1);
        check("t6_blk_count", 128'(blk_count), 128'd0);
        check("t6_busy", 128'(busy), 128'd0);
        repeat (20) @(negedge tb_clk);
        check("t6_no_late_out", 128'(out_valid), 128'd0);
        check("t6_no_err", 128'(err), 128'd0);
        push_blk(KAT_PT);
        wait_out("t6_chain");
        check("t6_chain_zero", out_data, KAT_CT);
        get_out("t6_chain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
